remote_led_engine: RTL and testbench

Parametrised successor to the single-RGB remote controller. It takes decoded remote button codes as a synchronous strobe and drives CHANNELS PWM LED outputs. It implements COLOR, FLASH, STROBE and a working SMOOTH (fade) mode, with brightness scaling folded into the duty value. It sits between the IR receiver/mapper and the LED pins, and the whole block runs on one clock domain.

---
 rtl/remote_led_engine_pkg.sv | 70 +++++++
 rtl/remote_led_engine_if.sv | 12 +
 rtl/remote_led_engine_pwm_channel_bank.sv | 50 +++++
 rtl/remote_led_engine.sv | 201 ++++++++++++++++++++
 tb/tb_remote_led_engine.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_led_engine_pkg.sv
// Shared types, button codes, palette and byte-to-resolution mapping for the LED engine.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package remote_led_pkg;

  typedef enum logic [1:0] {
    MODE_COLOR  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_STROBE = 2'd2,
    MODE_SMOOTH = 2'd3
  } mode_e;

  localparam int BTN_W = 5;
  localparam int PAL_N = 15;

  localparam logic [4:0] BTN_BRIGHT_UP  = 5'd0;
  localparam logic [4:0] BTN_BRIGHT_DN  = 5'd1;
  localparam logic [4:0] BTN_OFF        = 5'd2;
  localparam logic [4:0] BTN_ON         = 5'd3;
  localparam logic [4:0] BTN_WHITE      = 5'd7;
  localparam logic [4:0] BTN_FLASH      = 5'd11;
  localparam logic [4:0] BTN_STROBE     = 5'd15;
  localparam logic [4:0] BTN_SMOOTH     = 5'd19;
  localparam logic [4:0] BTN_MODE_CYCLE = 5'd23;
  localparam logic [4:0] BTN_INVALID    = 5'd31;

  // Selector values returned by btn_colour_sel besides a palette index.
  localparam logic [4:0] SEL_WHITE     = 5'd15;
  localparam logic [4:0] SEL_NO_COLOUR = 5'd31;

  localparam logic [23:0] WHITE = 24'hFFFFFF;

  // Index order: RED, RED1..4, GREEN, GREEN1..4, BLUE, BLUE1..4.
  localparam logic [23:0] PALETTE [PAL_N] = '{
    24'hFF0000, 24'hFF4000, 24'hFF8000, 24'hFFC000, 24'hFFFF00,
    24'h00FF00, 24'h00FF40, 24'h00FF80, 24'h00FFC0, 24'h00FFFF,
    24'h0000FF, 24'h4000FF, 24'h8000FF, 24'hC000FF, 24'hFF00FF
  };

  // Remote layout: one row per shade, columns R, G, B, then a function key.
  function automatic logic [4:0] btn_colour_sel(input logic [4:0] btn);
    case (btn)
      5'd4:    return 5'd0;
      5'd5:    return 5'd5;
      5'd6:    return 5'd10;
      5'd7:    return SEL_WHITE;
      5'd8:    return 5'd1;
      5'd9:    return 5'd6;
      5'd10:   return 5'd11;
      5'd12:   return 5'd2;
      5'd13:   return 5'd7;
      5'd14:   return 5'd12;
      5'd16:   return 5'd3;
      5'd17:   return 5'd8;
      5'd18:   return 5'd13;
      5'd20:   return 5'd4;
      5'd21:   return 5'd9;
      5'd22:   return 5'd14;
      default: return SEL_NO_COLOUR;
    endcase
  endfunction

  // Narrow resolutions keep the top bits; wide ones replicate the top bits into the LSBs
  // so that 0xFF maps to all-ones. Result is right-aligned; caller takes [res-1:0].
  function automatic logic [15:0] res_map(input logic [7:0] b, input int res);
    if (res <= 8) return 16'(b) >> (8 - res);
    else          return (16'(b) << (res - 8)) | (16'(b) >> (16 - res));
  endfunction

endpackage

// File: rtl/remote_led_engine_if.sv
// Decoded remote-button command bus between the IR mapper and the LED engine.
// Latency: wires only.
// Backpressure: none; the engine accepts a strobe on every cycle.
interface remote_led_engine_if;
  import remote_led_pkg::*;

  logic [BTN_W-1:0] button;
  logic             button_valid;

  modport master (output button, output button_valid);
  modport slave  (input  button, input  button_valid);
endinterface

// File: rtl/remote_led_engine_pwm_channel_bank.sv
// Free-running PWM counter with per-channel duty latch, compare and output polarity.
// Latency: duty takes effect at the next counter wrap; led is registered (1 cycle after inputs).
// Backpressure: none; duty_i is sampled once per period.
module pwm_channel_bank #(
  parameter int CHANNELS     = 3,
  parameter int RES          = 8,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0][RES-1:0] duty_i,
  input  logic                         light_on_i,
  output logic [CHANNELS-1:0]          led_o,
  output logic                         pwm_sync_o
);

  logic [RES-1:0]               cnt_q;
  logic [CHANNELS-1:0][RES-1:0] duty_q;
  logic [CHANNELS-1:0]          led_d, led_q;

  // Period counter wraps naturally at 2^RES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_q + RES'(1);
  end

  // Capture new duties on the last count so they govern the whole next period from count 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         duty_q <= '0;
    else if (&cnt_q)  duty_q <= duty_i;
  end

  // All-ones duty is forced fully on; otherwise high while the counter is below the duty.
  always_comb begin
    led_d = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      led_d[ch] = (((&duty_q[ch]) | (cnt_q < duty_q[ch])) & light_on_i) ^ COMMON_ANODE;
    end
  end

  // Registered drive so pins are glitch-free; reset parks them at the inactive level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= {CHANNELS{COMMON_ANODE}};
    else      led_q <= led_d;
  end

  assign led_o      = led_q;
  assign pwm_sync_o = (cnt_q == '0);

endmodule

// File: rtl/remote_led_engine.sv
// Remote-controlled multi-channel LED engine: command FSM, effect prescalers, colour/fade logic.
// Latency: button -> state 1 cycle; light_on -> led 1 more cycle; duty -> led at next PWM period.
// Backpressure: none; every button_valid strobe is consumed in its cycle.
module remote_led_engine
  import remote_led_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int RES          = 8,
  parameter int STEP_DIV     = 30_000_000,
  parameter int FADE_DIV     = 100_000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  remote_led_engine_if.slave   cmd,
  output logic [CHANNELS-1:0]  led,
  output logic                 pwm_sync,
  output logic [1:0]           mode,
  output logic                 light_on,
  output logic [2:0]           brightness
);

  typedef logic [CHANNELS-1:0][RES-1:0] chan_vec_t;

  localparam int SW = ($clog2(STEP_DIV) > 0) ? $clog2(STEP_DIV) : 1;
  localparam int FW = ($clog2(FADE_DIV) > 0) ? $clog2(FADE_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

  // Map a 24-bit RGB value to per-channel levels; a fourth channel gets min(R,G,B).
  function automatic chan_vec_t rgb_to_lvl(input logic [23:0] rgb);
    logic [15:0]    r16, g16, b16;
    logic [RES-1:0] w;
    chan_vec_t      v;
    r16  = res_map(rgb[23:16], RES);
    g16  = res_map(rgb[15:8],  RES);
    b16  = res_map(rgb[7:0],   RES);
    v    = '0;
    v[0] = r16[RES-1:0];
    v[1] = g16[RES-1:0];
    v[2] = b16[RES-1:0];
    w = (r16[RES-1:0] < g16[RES-1:0]) ? r16[RES-1:0] : g16[RES-1:0];
    if (b16[RES-1:0] < w) w = b16[RES-1:0];
    if (CHANNELS > 3) v[CHANNELS-1] = w;
    return v;
  endfunction

  mode_e          mode_q, mode_d;
  logic           light_on_q, light_on_d;
  logic [2:0]     bright_q, bright_d;
  logic [23:0]    color_q, color_d;
  logic           mode_cmd;
  logic [4:0]     sel;

  logic [3:0]     idx_q, idx_d, idx_inc;
  logic           strobe_on_q, strobe_on_d;
  chan_vec_t      fade_q, fade_d;
  logic [SW-1:0]  step_cnt_q, step_cnt_d;
  logic [FW-1:0]  fade_cnt_q, fade_cnt_d;
  logic           step_run, fade_run, step_tick, fade_tick;

  chan_vec_t      pal_lvl, col_lvl, level, duty;
  logic [3:0]     scale;
  logic [RES+2:0] prod [CHANNELS];

  // Command FSM state: mode plus the user-facing settings it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_COLOR;
      light_on_q <= 1'b1;
      bright_q   <= 3'd5;
      color_q    <= WHITE;
    end else begin
      mode_q     <= mode_d;
      light_on_q <= light_on_d;
      bright_q   <= bright_d;
      color_q    <= color_d;
    end
  end

  // Button decode; mode_cmd marks any accepted mode write so effect timing restarts cleanly.
  always_comb begin
    mode_d     = mode_q;
    light_on_d = light_on_q;
    bright_d   = bright_q;
    color_d    = color_q;
    mode_cmd   = 1'b0;
    sel        = btn_colour_sel(cmd.button);
    if (cmd.button_valid) begin
      case (cmd.button)
        BTN_BRIGHT_UP:  if (bright_q != 3'd7) bright_d = bright_q + 3'd1;
        BTN_BRIGHT_DN:  if (bright_q != 3'd0) bright_d = bright_q - 3'd1;
        BTN_OFF:        light_on_d = 1'b0;
        BTN_ON:         light_on_d = 1'b1;
        BTN_FLASH:      if (light_on_q) begin mode_d = MODE_FLASH;  mode_cmd = 1'b1; end
        BTN_STROBE:     if (light_on_q) begin mode_d = MODE_STROBE; mode_cmd = 1'b1; end
        BTN_SMOOTH:     if (light_on_q) begin mode_d = MODE_SMOOTH; mode_cmd = 1'b1; end
        BTN_MODE_CYCLE: if (light_on_q) begin mode_d = mode_e'(mode_q + 2'd1); mode_cmd = 1'b1; end
        default: begin
          if (light_on_q && sel != SEL_NO_COLOUR) begin
            color_d  = (sel == SEL_WHITE) ? WHITE : PALETTE[sel[3:0]];
            mode_d   = MODE_COLOR;
            mode_cmd = 1'b1;
          end
        end
      endcase
    end
  end

  assign idx_inc   = (idx_q == 4'(PAL_N - 1)) ? 4'd0 : idx_q + 4'd1;
  assign pal_lvl   = rgb_to_lvl(PALETTE[idx_q]);
  assign col_lvl   = rgb_to_lvl(color_q);
  assign step_run  = (mode_q == MODE_FLASH) || (mode_q == MODE_STROBE);
  assign fade_run  = (mode_q == MODE_SMOOTH);
  assign step_tick = step_run && (step_cnt_q == STEP_LAST);
  assign fade_tick = fade_run && (fade_cnt_q == FADE_LAST);

  // Effect state: palette index, strobe phase, fade levels and the two prescalers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      strobe_on_q <= 1'b1;
      fade_q      <= '0;
      step_cnt_q  <= '0;
      fade_cnt_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      strobe_on_q <= strobe_on_d;
      fade_q      <= fade_d;
      step_cnt_q  <= step_cnt_d;
      fade_cnt_q  <= fade_cnt_d;
    end
  end

  // Ticks advance the effect; a coincident mode command discards the tick and restarts timing.
  always_comb begin
    idx_d       = idx_q;
    strobe_on_d = strobe_on_q;
    fade_d      = fade_q;
    step_cnt_d  = '0;
    fade_cnt_d  = '0;
    if (mode_cmd) begin
      strobe_on_d = 1'b1;
    end else begin
      if (step_run && !step_tick) step_cnt_d = step_cnt_q + SW'(1);
      if (fade_run && !fade_tick) fade_cnt_d = fade_cnt_q + FW'(1);
      if (step_tick) begin
        if (mode_q == MODE_FLASH) begin
          idx_d = idx_inc;
        end else begin
          strobe_on_d = ~strobe_on_q;
          if (strobe_on_q) idx_d = idx_inc;
        end
      end
      if (fade_tick) begin
        if (fade_q == pal_lvl) begin
          idx_d = idx_inc;
        end else begin
          for (int ch = 0; ch < CHANNELS; ch++) begin
            if (fade_q[ch] < pal_lvl[ch])      fade_d[ch] = fade_q[ch] + RES'(1);
            else if (fade_q[ch] > pal_lvl[ch]) fade_d[ch] = fade_q[ch] - RES'(1);
          end
        end
      end
    end
  end

  // Per-mode level, then brightness scaling: (level * (brightness+1)) >> 3.
  always_comb begin
    case (mode_q)
      MODE_COLOR:  level = col_lvl;
      MODE_FLASH:  level = pal_lvl;
      MODE_STROBE: level = strobe_on_q ? pal_lvl : '0;
      default:     level = fade_q;
    endcase
    scale = {1'b0, bright_q} + 4'd1;
    duty  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      prod[ch] = (RES+3)'(level[ch]) * (RES+3)'(scale);
      duty[ch] = prod[ch][RES+2:3];
    end
  end

  pwm_channel_bank #(
    .CHANNELS     (CHANNELS),
    .RES          (RES),
    .COMMON_ANODE (COMMON_ANODE)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .duty_i     (duty),
    .light_on_i (light_on_q),
    .led_o      (led),
    .pwm_sync_o (pwm_sync)
  );

  assign mode       = mode_q;
  assign light_on   = light_on_q;
  assign brightness = bright_q;

endmodule

// File: tb/tb_remote_led_engine.sv
// Randomised and directed bench for remote_led_engine against a per-cycle behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_remote_led_engine;

  localparam int CH   = 3;
  localparam int RES  = 4;
  localparam int SD   = 4;
  localparam int FD   = 2;
  localparam int MAXV = (1 << RES) - 1;

  localparam logic [23:0] TB_WHITE = 24'hFFFFFF;
  // RED, RED1..4, GREEN, GREEN1..4, BLUE, BLUE1..4
  localparam logic [23:0] TB_PAL [15] = '{
    24'hFF0000, 24'hFF4000, 24'hFF8000, 24'hFFC000, 24'hFFFF00,
    24'h00FF00, 24'h00FF40, 24'h00FF80, 24'h00FFC0, 24'h00FFFF,
    24'h0000FF, 24'h4000FF, 24'h8000FF, 24'hC000FF, 24'hFF00FF
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] led;
  logic          pwm_sync;
  logic [1:0]    mode;
  logic          light_on;
  logic [2:0]    brightness;

  remote_led_engine_if cmd_if ();

  remote_led_engine #(
    .CHANNELS (CH), .RES (RES), .STEP_DIV (SD), .FADE_DIV (FD), .COMMON_ANODE (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .led        (led),
    .pwm_sync   (pwm_sync),
    .mode       (mode),
    .light_on   (light_on),
    .brightness (brightness)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_mode, m_light, m_bright, m_idx, m_sc, m_fc, m_cnt;
  bit          m_strobe;
  logic [23:0] m_color;
  int          m_fade [CH];
  int          m_lat  [CH];
  bit [CH-1:0] m_led;

  function automatic int chan(input logic [23:0] rgb, input int ch);
    int b;
    b = int'((rgb >> (16 - 8*ch)) & 24'hFF);
    if (RES <= 8) return b >> (8 - RES);
    return (b << (RES - 8)) | (b >> (16 - RES));
  endfunction

  function automatic int m_level(input int ch);
    case (m_mode)
      0:       return chan(m_color, ch);
      1:       return chan(TB_PAL[m_idx], ch);
      2:       return m_strobe ? chan(TB_PAL[m_idx], ch) : 0;
      default: return m_fade[ch];
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_light = 1; m_bright = 5; m_color = TB_WHITE; m_idx = 0;
      m_strobe = 1'b1; m_sc = 0; m_fc = 0; m_cnt = 0; m_led = '0;
      for (int c = 0; c < CH; c++) begin m_fade[c] = 0; m_lat[c] = 0; end
    end else begin : step
      int om, b, row, col, tgt;
      bit st, ft, cmd, at;
      // PWM output and period latch use the state from before this edge
      for (int c = 0; c < CH; c++)
        m_led[c] = (m_light != 0) && (m_lat[c] == MAXV || m_cnt < m_lat[c]);
      if (m_cnt == MAXV)
        for (int c = 0; c < CH; c++) m_lat[c] = (m_level(c) * (m_bright + 1)) >> 3;
      m_cnt = (m_cnt + 1) % (MAXV + 1);
      om  = m_mode;
      st  = (om == 1 || om == 2) && (m_sc == SD - 1);
      ft  = (om == 3) && (m_fc == FD - 1);
      cmd = 1'b0;
      if (cmd_if.button_valid) begin
        b = int'(cmd_if.button);
        if (b == 0)      begin if (m_bright < 7) m_bright++; end
        else if (b == 1) begin if (m_bright > 0) m_bright--; end
        else if (b == 2) m_light = 0;
        else if (b == 3) m_light = 1;
        else if (b >= 4 && b <= 23 && m_light != 0) begin
          // Keypad rows are shades, columns are R,G,B and a function key
          row = (b - 4) / 4;
          col = (b - 4) % 4;
          cmd = 1'b1;
          if (col < 3)        begin m_color = TB_PAL[col*5 + row]; m_mode = 0; end
          else if (row == 0)  begin m_color = TB_WHITE; m_mode = 0; end
          else if (row < 4)   m_mode = row;
          else                m_mode = (m_mode + 1) % 4;
        end
      end
      if (cmd) begin
        m_sc = 0; m_fc = 0; m_strobe = 1'b1;
      end else begin
        m_sc = ((om == 1 || om == 2) && !st) ? m_sc + 1 : 0;
        m_fc = ((om == 3) && !ft) ? m_fc + 1 : 0;
        if (st) begin
          if (om == 1) m_idx = (m_idx + 1) % 15;
          else begin
            if (m_strobe) m_idx = (m_idx + 1) % 15;
            m_strobe = !m_strobe;
          end
        end
        if (ft) begin
          at = 1'b1;
          for (int c = 0; c < CH; c++) if (m_fade[c] != chan(TB_PAL[m_idx], c)) at = 1'b0;
          if (at) m_idx = (m_idx + 1) % 15;
          else for (int c = 0; c < CH; c++) begin
            tgt = chan(TB_PAL[m_idx], c);
            if (m_fade[c] < tgt)      m_fade[c]++;
            else if (m_fade[c] > tgt) m_fade[c]--;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("led",        32'(led),        32'(m_led));
      check("pwm_sync",   32'(pwm_sync),   32'(m_cnt == 0));
      check("mode",       32'(mode),       32'(m_mode));
      check("light_on",   32'(light_on),   32'(m_light));
      check("brightness", 32'(brightness), 32'(m_bright));
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input int b);
    @(negedge clk);
    cmd_if.button       = 5'(b);
    cmd_if.button_valid = 1'b1;
    @(negedge clk);
    cmd_if.button_valid = 1'b0;
    cmd_if.button       = 5'd31;
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    repeat (MAXV + 1) begin
      @(negedge clk);
      n += int'(led[ch]);
    end
  endtask

  int n_hi;

  initial begin
    rst                 = 1'b0;
    cmd_if.button       = 5'd31;
    cmd_if.button_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode",   32'(mode),       32'd0);
    check("rst_light",  32'(light_on),   32'd1);
    check("rst_bright", 32'(brightness), 32'd5);
    check("rst_led",    32'(led),        32'd0);
    rst    = 1'b1;
    chk_en = 1'b1;

    // White at brightness 5: 15*6>>3 = 11 of 16 counts high
    repeat (40) @(negedge clk);
    count_high(0, n_hi); check("white_b5_r", 32'(n_hi), 32'd11);
    count_high(2, n_hi); check("white_b5_b", 32'(n_hi), 32'd11);

    // RED, brightness 3: 15*4>>3 = 7 counts; G and B dark
    press(4); press(1); press(1);
    repeat (40) @(negedge clk);
    count_high(0, n_hi); check("red_b3_r", 32'(n_hi), 32'd7);
    count_high(1, n_hi); check("red_b3_g", 32'(n_hi), 32'd0);
    count_high(2, n_hi); check("red_b3_b", 32'(n_hi), 32'd0);

    // Effects: flash (full palette wrap), strobe, smooth
    press(11); repeat (200) @(negedge clk);
    press(15); repeat (200) @(negedge clk);
    press(19); repeat (400) @(negedge clk);

    // Power off blocks mode buttons but not brightness
    press(2); press(11);
    repeat (3) @(negedge clk);
    check("off_mode_kept", 32'(mode),     32'd3);
    check("off_light",     32'(light_on), 32'd0);
    check("off_led_dark",  32'(led),      32'd0);
    press(0);
    @(negedge clk);
    check("off_bright_up", 32'(brightness), 32'd4);
    press(3);
    repeat (40) @(negedge clk);
    check("on_light", 32'(light_on), 32'd1);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_mode",   32'(mode),       32'd0);
    check("arst_bright", 32'(brightness), 32'd5);
    check("arst_led",    32'(led),        32'd0);
    check("arst_sync",   32'(pwm_sync),   32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Random button traffic, including invalid codes and tick collisions
    for (int i = 0; i < 80; i++) begin
      press($urandom_range(0, 31));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    press(3);
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
